// File: rtl/hack_screen_scanner_if.sv
// rtl/hack_screen_scanner_if.sv - screen memory read port between scanner and frame store
interface hack_screen_scanner_if;
  logic        rd_en;
  logic [12:0] rd_addr;
  logic [15:0] rd_data;

  modport master (output rd_en, output rd_addr, input rd_data);
  modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/hack_screen_scanner.sv
// rtl/hack_screen_scanner.sv - raster scan of the Hack screen memory into serial pixels with syncs
module hack_screen_scanner #(
  parameter int H_ACTIVE        = 512,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 64,
  parameter int H_BP            = 48,
  parameter int V_ACTIVE        = 256,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 22,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  hack_screen_scanner_if.master  mem,
  output logic                   pixel,
  output logic                   de,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // At least 9/8 bits so the {v, h[8:4]} address slice always exists.
  localparam int HW = ($clog2(H_TOTAL) > 9) ? $clog2(H_TOTAL) : 9;
  localparam int VW = ($clog2(V_TOTAL) > 8) ? $clog2(V_TOTAL) : 8;
  localparam logic SYNC_ON = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          active;
  logic          hs_on;
  logic          vs_on;
  logic          fetch;

  // Stage 1 state: one-cycle-delayed qualifiers plus the pixel shifter.
  logic          load1;
  logic          de1;
  logic          hs1;
  logic          vs1;
  logic          fs1;
  logic [15:0]   shreg;
  logic [15:0]   word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (h == HW'(H_TOTAL - 1)) begin
      h <= '0;
      v <= (v == VW'(V_TOTAL - 1)) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  always_comb begin
    active = (h < HW'(H_ACTIVE)) && (v < VW'(V_ACTIVE));
    hs_on  = (h >= HW'(H_ACTIVE + H_FP)) && (h < HW'(H_ACTIVE + H_FP + H_SYNC));
    vs_on  = (v >= VW'(V_ACTIVE + V_FP)) && (v < VW'(V_ACTIVE + V_FP + V_SYNC));
    // Gated by reset so the port is idle while the counters are held at 0,0.
    fetch  = active && (h[3:0] == 4'd0) && !reset;
  end

  assign mem.rd_en   = fetch;
  assign mem.rd_addr = fetch ? {v[7:0], h[8:4]} : 13'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load1 <= 1'b0;
      de1   <= 1'b0;
      hs1   <= 1'b0;
      vs1   <= 1'b0;
      fs1   <= 1'b0;
    end else begin
      load1 <= fetch;
      de1   <= active;
      hs1   <= hs_on;
      vs1   <= vs_on;
      fs1   <= (h == '0) && (v == '0);
    end
  end

  // rd_data is only looked at in the response cycle; otherwise the shifter drains LSB first.
  assign word = load1 ? mem.rd_data : shreg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg       <= '0;
      pixel       <= 1'b0;
      de          <= 1'b0;
      hsync       <= ~SYNC_ON;
      vsync       <= ~SYNC_ON;
      frame_start <= 1'b0;
    end else begin
      shreg       <= {1'b0, word[15:1]};
      pixel       <= de1 & word[0];
      de          <= de1;
      hsync       <= hs1 ? SYNC_ON : ~SYNC_ON;
      vsync       <= vs1 ? SYNC_ON : ~SYNC_ON;
      frame_start <= fs1;
    end
  end
endmodule

// File: tb/tb_hack_screen_scanner.sv
// tb/tb_hack_screen_scanner.sv - directed bench for hack_screen_scanner on a reduced raster
module tb_hack_screen_scanner;
  localparam int HA = 32, HF = 4, HS = 8, HB = 4;
  localparam int VA = 4, VF = 2, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;   // 48
  localparam int VT = VA + VF + VS + VB;   // 10
  localparam int FRAME = HT * VT;          // 480

  typedef struct packed {
    int   h;
    int   v;
    logic [4:0] exp;   // {pixel, de, hsync, vsync, frame_start}
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic junk = 1'b0;
  logic pixel, de, hsync, vsync, frame_start;
  logic [15:0] mem [0:8191];
  logic [4:0] cap [0:FRAME-1];
  vec_t vecs [0:19];
  int checks = 0;
  int failures = 0;
  int cyc;

  hack_screen_scanner_if bus ();

  hack_screen_scanner #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .mem(bus.master),
    .pixel(pixel), .de(de), .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    bus.rd_data <= bus.rd_en ? mem[bus.rd_addr] : (junk ? 16'hFFFF : 16'h0000);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] model(input int h, input int v);
    logic [15:0] w;
    logic act;
    act = (h < HA) && (v < VA);
    w = act ? mem[v * 32 + h / 16] : 16'h0000;
    return {act & w[h % 16], act,
            !((h >= HA + HF) && (h < HA + HF + HS)),
            !((v >= VA + VF) && (v < VA + VF + VS)),
            (h == 0) && (v == 0)};
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_rd_en"}, bus.rd_en, 0);
    check({tag, "_rd_addr"}, bus.rd_addr, 0);
    check({tag, "_outs"}, {pixel, de, hsync, vsync, frame_start}, 5'b00110);
  endtask

  initial begin
    int rd_cnt, en_bad, mdl_bad, de_cnt, fs_cnt, pix_cnt, h, v;
    int addrs[$];
    vecs[0]  = '{0, 0, 5'b11111};   vecs[1]  = '{1, 0, 5'b01110};
    vecs[2]  = '{15, 0, 5'b01110};  vecs[3]  = '{16, 0, 5'b01110};
    vecs[4]  = '{31, 0, 5'b11110};  vecs[5]  = '{32, 0, 5'b00110};
    vecs[6]  = '{35, 0, 5'b00110};  vecs[7]  = '{36, 0, 5'b00010};
    vecs[8]  = '{43, 0, 5'b00010};  vecs[9]  = '{44, 0, 5'b00110};
    vecs[10] = '{18, 2, 5'b11110};  vecs[11] = '{15, 3, 5'b01110};
    vecs[12] = '{16, 3, 5'b11110};  vecs[13] = '{31, 3, 5'b11110};
    vecs[14] = '{32, 3, 5'b00110};  vecs[15] = '{0, 4, 5'b00110};
    vecs[16] = '{47, 5, 5'b00110};  vecs[17] = '{0, 6, 5'b00100};
    vecs[18] = '{40, 7, 5'b00000};  vecs[19] = '{0, 8, 5'b00110};
    for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;
    mem[0] = 16'h0001; mem[1] = 16'h8000; mem[65] = 16'h0004; mem[97] = 16'hFFFF;

    repeat (3) @(negedge clk);
    #1 check_reset_values("reset");
    @(negedge clk);
    reset = 1'b0;
    rd_cnt = 0; en_bad = 0;
    for (cyc = 0; cyc < FRAME + 3; ) begin
      #1;
      if (cyc < FRAME) begin
        h = cyc % HT; v = cyc / HT;
        if (bus.rd_en !== ((h < HA) && (v < VA) && (h % 16 == 0))) en_bad++;
        if (bus.rd_en === 1'b1) begin rd_cnt++; addrs.push_back(int'(bus.rd_addr)); end
      end
      if (cyc == FRAME) begin
        check("next_frame_rd_en", bus.rd_en, 1);
        check("next_frame_rd_addr", bus.rd_addr, 0);
      end
      if (cyc >= 2 && cyc - 2 < FRAME) cap[cyc - 2] = {pixel, de, hsync, vsync, frame_start};
      @(negedge clk);
      cyc++;
    end

    check("read_count", rd_cnt, 8);
    check("rd_en_pattern_bad_cycles", en_bad, 0);
    for (int i = 0; i < 8 && i < addrs.size(); i++)
      check($sformatf("rd_addr_%0d", i), addrs[i], (i / 2) * 32 + (i % 2));
    for (int i = 0; i < 20; i++)
      check($sformatf("vec_h%0d_v%0d", vecs[i].h, vecs[i].v),
            cap[vecs[i].v * HT + vecs[i].h], vecs[i].exp);
    mdl_bad = 0; de_cnt = 0; fs_cnt = 0;
    for (int k = 0; k < FRAME; k++) begin
      if (cap[k] !== model(k % HT, k / HT)) mdl_bad++;
      if (cap[k][3] === 1'b1) de_cnt++;
      if (cap[k][0] === 1'b1) fs_cnt++;
    end
    check("frame_model_bad_cycles", mdl_bad, 0);
    check("de_cycles", de_cnt, HA * VA);
    check("frame_start_pulses", fs_cnt, 1);

    // Mid-frame reset: counters at (20,2), outputs show (18,2) which is a black pixel.
    while (cyc < FRAME + 2 * HT + 20) begin @(negedge clk); cyc++; end
    #1 check("pre_reset_outs", {pixel, de}, 2'b11);
    #2 reset = 1'b1;
    #1 check_reset_values("async_reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1 check("post_reset_rd_en", bus.rd_en, 1);
    check("post_reset_rd_addr", bus.rd_addr, 0);
    check("post_reset_fs_c0", frame_start, 0);
    @(negedge clk); #1 check("post_reset_fs_c1", frame_start, 0);
    @(negedge clk); #1 check("post_reset_fs_c2", {pixel, de, frame_start}, 3'b111);

    // Junk on rd_data outside response cycles must never reach the pixel.
    @(negedge clk);
    reset = 1'b1;
    junk = 1'b1;
    for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;
    @(negedge clk);
    reset = 1'b0;
    pix_cnt = 0; rd_cnt = 0; de_cnt = 0;
    for (int n = 0; n < FRAME + 2; n++) begin
      #1;
      if (pixel !== 1'b0) pix_cnt++;
      if (de === 1'b1) de_cnt++;
      if (n < FRAME && bus.rd_en === 1'b1) rd_cnt++;
      @(negedge clk);
    end
    check("junk_pixel_ones", pix_cnt, 0);
    check("junk_read_count", rd_cnt, 8);
    check("junk_de_cycles", de_cnt, HA * VA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hack_screen_scanner.md
Name: hack_screen_scanner

Overview:
- Read-side engine for the Hack 512x256 monochrome screen memory (word addresses 0..8191, 32 words per row).
- Walks the frame in raster order and fetches screen words through a 1-cycle-latency read port.
- Serialises each word into one pixel per clock and generates hsync/vsync/data-enable for a display encoder.
- Sits between the screen memory's read port and the video output pins; the CPU remains the only writer.

Parameters:
- H_ACTIVE, 512, visible pixels per line; must be a multiple of 16.
- H_FP, 16, horizontal front porch, in clocks.
- H_SYNC, 64, horizontal sync width, in clocks.
- H_BP, 48, horizontal back porch, in clocks.
- V_ACTIVE, 256, visible lines per frame.
- V_FP, 10, vertical front porch, in lines.
- V_SYNC, 2, vertical sync width, in lines.
- V_BP, 22, vertical back porch, in lines.
- SYNC_ACTIVE_LOW, 1, 1 = sync pulses drive 0; 0 = sync pulses drive 1.

Ports:
- clk  input  1  pixel clock; every edge advances one pixel.
- reset  input  1  asynchronous, active-high reset.
- rd_en  output  1  screen read request, one cycle.
- rd_addr  output  13  screen word address; valid only while rd_en=1.
- rd_data  input  16  screen word; valid the cycle after rd_en.
- pixel  output  1  1 = black (Hack convention), 0 = white; forced 0 while de=0.
- de  output  1  active-video qualifier.
- hsync  output  1  horizontal sync.
- vsync  output  1  vertical sync.
- frame_start  output  1  one-cycle pulse aligned with the first active pixel (x=0, y=0) on the outputs.

Behaviour:
- Counters: h counts 0..H_TOTAL-1 (H_TOTAL = sum of H_*; 640 by default) and v counts 0..V_TOTAL-1 (290 by default).
  - h wraps to 0 at H_TOTAL-1.
  - v increments on h wrap, then wraps to 0 at V_TOTAL-1.
  - Active region is h<H_ACTIVE and v<V_ACTIVE.
  - Sync asserts for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) and for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- Fetch (stage 0):
  - rd_en=1 exactly when the position is active and h[3:0]==0.
  - rd_addr = v*32 + h[8:4], computed at 13-bit width with no overflow (max 8191).
  - This gives exactly 32 reads per active line and 8192 per frame; no reads occur in blanking.
- Stage 1:
  - rd_data is captured into a 16-bit shift register.
  - Pixel order is LSB first: bit 0 of the word at column x is pixel 16x+0, bit 15 is pixel 16x+15.
- Output (stage 2):
  - pixel, de, hsync, vsync and frame_start are all registered.
  - Every output shows counter position (h,v) exactly 2 cycles after the counters held (h,v); sync and de are delayed through the same 2-stage pipe, so all outputs stay mutually aligned.
- Phase stability: shift-register loads occur every 16th cycle within the line, with no gaps, and the 16 pixels of a word appear on consecutive cycles.
- rd_data is sampled only in the cycle after rd_en; its value at any other time has no effect.
- Memory writes racing a read: the scanner displays whatever word the port returns; no coherence logic.
- Reset values (asynchronous):
  - h=0, v=0, pipeline cleared.
  - rd_en=0, rd_addr=0, pixel=0, de=0, frame_start=0.
  - hsync=vsync=inactive level (1 if SYNC_ACTIVE_LOW else 0).
- Reset mid-frame: all outputs go to reset values immediately. After deassertion the first edge has h=0,v=0, so rd_en=1 with rd_addr=0 on that cycle and frame_start pulses 2 cycles later.
- Sync polarity applies to hsync/vsync only; de and pixel are always active-high.

Test Plan:
- Release reset, run 1 frame (640*290=185600 cycles) -> 8192 reads with addresses 0..8191 in order; rd_en high on cycles where h%16==0 only; frame_start pulses once, 2 cycles after the first read.
- Model memory with word[0]=16'h0001 and word[1]=16'h8000, all others 0 -> line 0 shows pixel=1 at x=0 and x=31 only; de high for exactly 512 consecutive cycles per active line.
- Check line timing -> hsync low for 64 cycles starting 16 cycles after de falls; per frame, vsync low for 2 full lines (1280 cycles) starting 10 lines after the last active line; de never high during vsync.
- Set word[8191]=16'hFFFF -> the last 16 pixels of line 255 are 1, then de falls; no read is issued between the end of line 255 and the next frame's h=0,v=0.
- Assert reset for 3 cycles at v=100,h=200 -> outputs immediately show reset values; after release, first rd_addr=0 and frame_start pulses 2 cycles later.
- Drive rd_data to 16'hFFFF on non-read cycles and 0 on read-response cycles -> pixel stays 0 for the whole frame.
